// File: rtl/param_seq_detector.sv
// Serial pattern detector with a loadable pattern, optional overlap and a
// saturating match counter. The output can be combinational (Mealy) or
// registered one cycle later in time (Moore).
module param_seq_detector #(
  parameter int unsigned        SEQ_LEN   = 4,
  parameter logic [SEQ_LEN-1:0] RESET_PAT = SEQ_LEN'(4'b1011),
  parameter bit                 OVERLAP   = 1'b1,
  parameter bit                 MEALY     = 1'b1,
  parameter int unsigned        CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic [SEQ_LEN-1:0] pattern,
  input  logic               load,
  input  logic               clear_cnt,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam int unsigned         FILL_W   = $clog2(SEQ_LEN);
  localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  logic [SEQ_LEN-1:0] r_pat;
  logic [SEQ_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_cnt;

  logic [SEQ_LEN-1:0] w_window;
  logic               w_accept;
  logic               w_full;
  logic               w_match;

  // The candidate window is the stored history with the incoming bit appended
  // as the newest (least significant) position.
  assign w_window = {r_hist, din};
  assign w_accept = din_valid & ~load;
  assign w_full   = (r_fill == FILL_MAX);
  assign w_match  = w_accept & w_full & (w_window == r_pat);

  // Pattern register, bit history and fill level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat  <= RESET_PAT;
      r_hist <= '0;
      r_fill <= '0;
    end else if (load) begin
      r_pat  <= pattern;
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      if (w_match && !OVERLAP) begin
        // Non-overlapping: the matched bits may not start the next match.
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_window[SEQ_LEN-2:0];
        if (!w_full) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
    end
  end

  // Saturating match counter; a clear that coincides with a match keeps that match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear_cnt) begin
      r_cnt <= w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_count = r_cnt;
  assign count_sat   = &r_cnt;

  if (MEALY) begin : g_mealy
    assign detected = w_match;
  end else begin : g_moore
    logic r_det;

    // Registered detect: one-cycle pulse following the completing bit's edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_det <= 1'b0;
      end else begin
        r_det <= w_match;
      end
    end

    assign detected = r_det;
  end

endmodule
